camera_sccb_config: RTL

Sequences power-up configuration of the camera sensor over SCCB (3-phase write: slave ID, register address, data). It walks an external register table of {addr,value} words, serialises each entry onto the open-drain sioc/siod bus, and honours table-embedded delay and end markers. It sits beside the pixel capture path; capture is held off until `done` is high.

---
 rtl/camera_sccb_config.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/camera_sccb_config.sv
// camera_sccb_config: walks a {reg,val} table and writes each entry to the
// camera sensor as a 3-phase SCCB write (slave ID, register, value).
// Table word 16'hFFFF ends the pass, 16'hFFF0 inserts a DELAY_CYCLES wait.
// Optional build macro SCCB_ACK_CHECK_EN: when defined, a high siod_in in the
// ninth bit of any byte flags error and aborts the pass after a stop.
module camera_sccb_config #(
    parameter int         CLK_FREQ_HZ  = 25000000,
    parameter int         SCCB_FREQ_HZ = 100000,
    parameter logic [7:0] SLAVE_ID     = 8'h42,
    parameter int         TABLE_AW     = 8,
    parameter int         DELAY_CYCLES = 250000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic [TABLE_AW-1:0] tbl_addr,
    input  logic [15:0]         tbl_data,
    output logic                sioc,
    output logic                siod_oe,
    input  logic                siod_in,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int Q_RAW = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int Q     = (Q_RAW < 1) ? 1 : Q_RAW;
    localparam logic [31:0]         TICK_LAST  = 32'(Q - 1);
    localparam logic [31:0]         DELAY_LAST = 32'(DELAY_CYCLES - 1);
    localparam logic [TABLE_AW-1:0] ADDR_MAX   = '1;
    localparam logic [7:0]          SLAVE_WR   = {SLAVE_ID[7:1], 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_BYTE, S_STOP, S_GAP, S_DELAY, S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           cyc_q, cyc_d;       // clk count inside the current tick / delay
    logic [1:0]            ph_q, ph_d;         // tick index inside START/bit/STOP/GAP
    logic [3:0]            bit_q, bit_d;       // 0..7 data, 8 = ACK slot
    logic [1:0]            byte_q, byte_d;     // 0 = slave ID, 1 = reg, 2 = val
    logic [7:0]            reg_q, reg_d;
    logic [7:0]            val_q, val_d;
    logic [TABLE_AW-1:0]   tbl_addr_q, tbl_addr_d;
    logic                  sioc_q, sioc_d;
    logic                  siod_oe_q, siod_oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  nack_q, nack_d;
    logic                  tick, advance, finish, ack_fail;

`ifdef SCCB_ACK_CHECK_EN
    assign ack_fail = siod_in;
`else
    logic unused_siod_in;
    assign unused_siod_in = siod_in;
    assign ack_fail       = 1'b0;
`endif

    assign tick = (cyc_q == TICK_LAST);

    // Level driven on siod for a given bit slot; the ACK slot is released.
    function automatic logic bit_level(input logic [1:0] byte_sel, input logic [3:0] bit_sel,
                                       input logic [7:0] r, input logic [7:0] v);
        logic [7:0] cur;
        cur = (byte_sel == 2'd0) ? SLAVE_WR : (byte_sel == 2'd1) ? r : v;
        if (bit_sel >= 4'd8) return 1'b1;
        return cur[3'(4'd7 - bit_sel)];
    endfunction

    // Next-state, counter and output computation for the whole sequencer.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cyc_d      = cyc_q;
        ph_d       = ph_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        reg_d      = reg_q;
        val_d      = val_q;
        tbl_addr_d = tbl_addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        nack_d     = nack_q;
        advance    = 1'b0;
        finish     = 1'b0;

        case (state_q)
            S_IDLE, S_FINISH: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d    = S_FETCH;
                    tbl_addr_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    nack_d     = 1'b0;
                end
            end
            S_FETCH: begin
                cyc_d = '0;
                ph_d  = '0;
                if (tbl_data == 16'hFFFF) begin
                    finish = 1'b1;
                end else if (tbl_data == 16'hFFF0) begin
                    state_d = S_DELAY;
                end else begin
                    reg_d   = tbl_data[15:8];
                    val_d   = tbl_data[7:0];
                    state_d = S_START;
                end
            end
            S_START: begin
                cyc_d = tick ? '0 : cyc_q + 32'd1;
                if (tick) begin
                    if (ph_q == 2'd1) begin
                        state_d = S_BYTE;
                        ph_d    = '0;
                        bit_d   = '0;
                        byte_d  = '0;
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end
            end
            S_BYTE: begin
                cyc_d = tick ? '0 : cyc_q + 32'd1;
                if (tick) begin
                    ph_d = ph_q + 2'd1;
                    // Tick 2 of the ACK slot: sioc is high mid-bit, slave drives the line.
                    if (ph_q == 2'd1 && bit_q == 4'd8 && ack_fail) begin
                        nack_d  = 1'b1;
                        error_d = 1'b1;
                    end
                    if (ph_q == 2'd3) begin
                        if (bit_q == 4'd8) begin
                            bit_d = '0;
                            if (byte_q == 2'd2 || nack_q) state_d = S_STOP;
                            else                          byte_d  = byte_q + 2'd1;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                cyc_d = tick ? '0 : cyc_q + 32'd1;
                if (tick) begin
                    if (ph_q == 2'd1) begin
                        ph_d = '0;
                        if (nack_q) finish  = 1'b1;
                        else        state_d = S_GAP;
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end
            end
            S_GAP: begin
                cyc_d = tick ? '0 : cyc_q + 32'd1;
                if (tick) begin
                    if (ph_q == 2'd3) advance = 1'b1;
                    ph_d = ph_q + 2'd1;
                end
            end
            S_DELAY: begin
                cyc_d = cyc_q + 32'd1;
                if (cyc_q == DELAY_LAST) begin
                    cyc_d   = '0;
                    advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The last table slot ends the pass even without an end marker.
        if (advance) begin
            if (tbl_addr_q == ADDR_MAX) begin
                finish = 1'b1;
            end else begin
                tbl_addr_d = tbl_addr_q + TABLE_AW'(1);
                state_d    = S_FETCH;
            end
        end
        if (finish) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        // Bus levels follow the state being entered so they are registered with it.
        sioc_d    = 1'b1;
        siod_oe_d = 1'b0;
        case (state_d)
            S_START: siod_oe_d = 1'b1;
            S_BYTE: begin
                sioc_d    = (ph_d == 2'd1) || (ph_d == 2'd2);
                siod_oe_d = ~bit_level(byte_d, bit_d, reg_d, val_d);
            end
            S_STOP: begin
                sioc_d    = (ph_d == 2'd1);
                siod_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset releases the bus immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            ph_q       <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            reg_q      <= '0;
            val_q      <= '0;
            tbl_addr_q <= '0;
            sioc_q     <= 1'b1;
            siod_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            reg_q      <= reg_d;
            val_q      <= val_d;
            tbl_addr_q <= tbl_addr_d;
            sioc_q     <= sioc_d;
            siod_oe_q  <= siod_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            nack_q     <= nack_d;
        end
    end

    assign tbl_addr = tbl_addr_q;
    assign sioc     = sioc_q;
    assign siod_oe  = siod_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
